// File: rtl/uart_frame_loader.sv
// uart_frame_loader
//   Receives 8x8x8 light-cube frames over a UART 8N1 line and presents the
//   most recent complete, checksum-valid frame as one 512-bit word.
//   Frame format on the wire: SYNC_BYTE, 64 data bytes, XOR checksum of the
//   64 data bytes. Bytes are collected in a shadow buffer and copied to the
//   output register only after the checksum matches.
// Ports:
//   clk             system clock, rising edge
//   resetn          asynchronous active-low reset
//   rx              UART serial input, idle high, asynchronous to clk
//   frame_cube_flat current frame; byte k sits at [8*(63-k)+7 : 8*(63-k)]
//   frame_update    one-cycle pulse when frame_cube_flat takes a new frame
//   busy            high while a frame is in progress
//   err_cnt         saturating count of aborted frames
module uart_frame_loader #(
  parameter int         CLK_FREQ     = 100_000_000,
  parameter int         BAUD         = 115200,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter int         TIMEOUT_BITS = 32
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         rx,
  output logic [511:0] frame_cube_flat,
  output logic         frame_update,
  output logic         busy,
  output logic [7:0]   err_cnt
);

  localparam logic [31:0] CLKS_PER_BIT = 32'(CLK_FREQ / BAUD);
  localparam logic [31:0] HALF_BIT     = 32'((CLK_FREQ / BAUD) / 2);
  localparam logic [31:0] TIMEOUT_CLKS = 32'(TIMEOUT_BITS * (CLK_FREQ / BAUD));

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  localparam logic [1:0] F_WAIT_SYNC = 2'd0;
  localparam logic [1:0] F_DATA      = 2'd1;
  localparam logic [1:0] F_CHECK     = 2'd2;

  // Running XOR checksum step.
  function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] data);
    return acc ^ data;
  endfunction

  logic         rx_meta_r, rx_sync_r;
  logic [1:0]   rx_state_r;
  logic [31:0]  clk_cnt_r;
  logic [2:0]   bit_idx_r;
  logic [7:0]   shift_r;
  logic         byte_valid_r;
  logic [7:0]   byte_data_r;
  logic         frame_err_r;

  logic [1:0]   state_r, state_nxt_s;
  logic [5:0]   idx_r;
  logic [7:0]   csum_r;
  logic [511:0] shadow_r;
  logic [511:0] frame_r;
  logic         update_r;
  logic         busy_r;
  logic [7:0]   err_cnt_r;
  logic [31:0]  idle_cnt_r;
  logic         timeout_s;
  logic         start_s, store_s, load_s, abort_s;

  assign frame_cube_flat = frame_r;
  assign frame_update    = update_r;
  assign busy            = busy_r;
  assign err_cnt         = err_cnt_r;
  assign timeout_s       = (idle_cnt_r == TIMEOUT_CLKS);

  // Two-flop synchronizer for the asynchronous rx line; resets to idle-high.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
    end else begin
      rx_meta_r <= rx;
      rx_sync_r <= rx_meta_r;
    end
  end

  // UART 8N1 receiver: mid-bit sampling, one-cycle byte_valid / frame_err pulses.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_state_r   <= RX_IDLE;
      clk_cnt_r    <= 32'd0;
      bit_idx_r    <= 3'd0;
      shift_r      <= 8'd0;
      byte_valid_r <= 1'b0;
      byte_data_r  <= 8'd0;
      frame_err_r  <= 1'b0;
    end else begin
      byte_valid_r <= 1'b0;
      frame_err_r  <= 1'b0;
      case (rx_state_r)
        RX_IDLE: begin
          clk_cnt_r <= 32'd0;
          if (!rx_sync_r) rx_state_r <= RX_START;
        end
        RX_START: begin
          if (clk_cnt_r == HALF_BIT - 32'd1) begin
            clk_cnt_r  <= 32'd0;
            bit_idx_r  <= 3'd0;
            // A line that is high again at mid-start-bit was only a glitch.
            rx_state_r <= rx_sync_r ? RX_IDLE : RX_DATA;
          end else begin
            clk_cnt_r <= clk_cnt_r + 32'd1;
          end
        end
        RX_DATA: begin
          if (clk_cnt_r == CLKS_PER_BIT - 32'd1) begin
            clk_cnt_r <= 32'd0;
            shift_r   <= {rx_sync_r, shift_r[7:1]};
            bit_idx_r <= bit_idx_r + 3'd1;
            if (bit_idx_r == 3'd7) rx_state_r <= RX_STOP;
          end else begin
            clk_cnt_r <= clk_cnt_r + 32'd1;
          end
        end
        RX_STOP: begin
          if (clk_cnt_r == CLKS_PER_BIT - 32'd1) begin
            clk_cnt_r  <= 32'd0;
            rx_state_r <= RX_IDLE;
            if (rx_sync_r) begin
              byte_valid_r <= 1'b1;
              byte_data_r  <= shift_r;
            end else begin
              frame_err_r <= 1'b1;
            end
          end else begin
            clk_cnt_r <= clk_cnt_r + 32'd1;
          end
        end
        default: rx_state_r <= RX_IDLE;
      endcase
    end
  end

  // Framer next-state and action decode.
  always_comb begin
    state_nxt_s = state_r;
    start_s     = 1'b0;
    store_s     = 1'b0;
    load_s      = 1'b0;
    abort_s     = 1'b0;
    case (state_r)
      F_WAIT_SYNC: begin
        if (byte_valid_r && (byte_data_r == SYNC_BYTE)) begin
          start_s     = 1'b1;
          state_nxt_s = F_DATA;
        end else begin
          state_nxt_s = F_WAIT_SYNC;
        end
      end
      F_DATA: begin
        if (frame_err_r || (!byte_valid_r && timeout_s)) begin
          abort_s     = 1'b1;
          state_nxt_s = F_WAIT_SYNC;
        end else if (byte_valid_r) begin
          // A sync-valued byte here is ordinary data.
          store_s     = 1'b1;
          state_nxt_s = (idx_r == 6'd63) ? F_CHECK : F_DATA;
        end else begin
          state_nxt_s = F_DATA;
        end
      end
      F_CHECK: begin
        if (byte_valid_r && (byte_data_r == csum_r)) begin
          load_s      = 1'b1;
          state_nxt_s = F_WAIT_SYNC;
        end else if (byte_valid_r || frame_err_r || timeout_s) begin
          abort_s     = 1'b1;
          state_nxt_s = F_WAIT_SYNC;
        end else begin
          state_nxt_s = F_CHECK;
        end
      end
      default: state_nxt_s = F_WAIT_SYNC;
    endcase
  end

  // Framer state, shadow buffer, output register and error counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r   <= F_WAIT_SYNC;
      idx_r     <= 6'd0;
      csum_r    <= 8'd0;
      shadow_r  <= 512'd0;
      frame_r   <= 512'd0;
      update_r  <= 1'b0;
      busy_r    <= 1'b0;
      err_cnt_r <= 8'd0;
    end else begin
      state_r  <= state_nxt_s;
      busy_r   <= (state_nxt_s != F_WAIT_SYNC);
      update_r <= load_s;
      if (start_s) begin
        idx_r  <= 6'd0;
        csum_r <= 8'd0;
      end else if (store_s) begin
        // Slot base 8*(63-idx): for a 6-bit idx, 63-idx is just ~idx.
        shadow_r[{~idx_r, 3'b000} +: 8] <= byte_data_r;
        csum_r <= csum_step(csum_r, byte_data_r);
        idx_r  <= idx_r + 6'd1;
      end
      if (load_s) frame_r <= shadow_r;
      if (abort_s && (err_cnt_r != 8'hFF)) err_cnt_r <= err_cnt_r + 8'd1;
    end
  end

  // Inter-byte idle counter; only meaningful while a frame is in progress.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      idle_cnt_r <= 32'd0;
    end else if ((state_r == F_WAIT_SYNC) || byte_valid_r || (rx_state_r != RX_IDLE)) begin
      idle_cnt_r <= 32'd0;
    end else if (!timeout_s) begin
      idle_cnt_r <= idle_cnt_r + 32'd1;
    end
  end

endmodule

// File: tb/tb_uart_frame_loader.sv
module tb_uart_frame_loader;
  localparam int CPB = 16;

  logic         clk = 1'b0;
  logic         resetn;
  logic         rx;
  logic [511:0] frame_cube_flat;
  logic         frame_update;
  logic         busy;
  logic [7:0]   err_cnt;

  uart_frame_loader #(
    .CLK_FREQ(1600), .BAUD(100), .SYNC_BYTE(8'hA5), .TIMEOUT_BITS(32)
  ) dut (
    .clk(clk), .resetn(resetn), .rx(rx),
    .frame_cube_flat(frame_cube_flat), .frame_update(frame_update),
    .busy(busy), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int           checks = 0;
  int           errors = 0;
  logic [511:0] exp_q[$];
  logic [511:0] last_frame = 512'd0;
  int           exp_err = 0;
  bit           prev_upd = 1'b0;

  typedef struct {
    logic [7:0] base;
    logic [7:0] step;
    logic [7:0] cx;       // XORed into the correct checksum before sending
    bit         accept;
    int         err_after;
  } vec_t;
  vec_t vecs[4];

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard: each frame_update pops the frame pushed when it was sent.
  always @(negedge clk) begin
    if (resetn && frame_update) begin
      check_int("update_one_cycle", int'(prev_upd), 0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_update: got pulse with frame %h expected none", frame_cube_flat);
      end else begin
        check("frame_data", frame_cube_flat, exp_q.pop_front());
      end
    end
    prev_upd = resetn && frame_update;
  end

  task automatic send_byte(input logic [7:0] b, input bit stop_low);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_low ? 1'b0 : 1'b1;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask

  // Sync byte plus ndata data bytes; a full frame also gets its checksum.
  task automatic send_frame(input logic [7:0] base, input logic [7:0] step, input logic [7:0] cx,
                            input int ndata, input int bad_idx, input bit accept);
    logic [511:0] f;
    logic [7:0]   cs;
    logic [7:0]   d;
    f  = 512'd0;
    cs = 8'd0;
    send_byte(8'hA5, 1'b0);
    for (int k = 0; k < ndata; k++) begin
      d = base + 8'(k) * step;
      f[8*(63-k) +: 8] = d;
      cs = cs ^ d;
      send_byte(d, k == bad_idx);
    end
    if (ndata == 64) begin
      if (accept) begin
        exp_q.push_back(f);
        last_frame = f;
      end else begin
        exp_err++;
      end
      send_byte(cs ^ cx, 1'b0);
    end
  endtask

  task automatic after_frame(input string tag);
    check({tag, "_frame"}, frame_cube_flat, last_frame);
    check_int({tag, "_err_cnt"}, int'(err_cnt), exp_err);
    check_int({tag, "_busy"}, int'(busy), 0);
    check_int({tag, "_pending"}, exp_q.size(), 0);
  endtask

  initial begin
    vecs[0] = '{base: 8'h00, step: 8'h01, cx: 8'h00, accept: 1'b1, err_after: 0};
    vecs[1] = '{base: 8'hFF, step: 8'h00, cx: 8'h00, accept: 1'b1, err_after: 0};
    vecs[2] = '{base: 8'hFF, step: 8'h00, cx: 8'h01, accept: 1'b0, err_after: 1};
    vecs[3] = '{base: 8'hA5, step: 8'h00, cx: 8'h00, accept: 1'b1, err_after: 1};

    rx = 1'b1;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_frame", frame_cube_flat, 512'd0);
    check_int("reset_update", int'(frame_update), 0);
    check_int("reset_busy", int'(busy), 0);
    check_int("reset_err", int'(err_cnt), 0);
    resetn = 1'b1;
    repeat (2 * CPB) @(negedge clk);

    // Table: frames sent back to back with no idle gap.
    for (int v = 0; v < 4; v++) begin
      send_frame(vecs[v].base, vecs[v].step, vecs[v].cx, 64, -1, vecs[v].accept);
      after_frame($sformatf("vec%0d", v));
      check_int($sformatf("vec%0d_err_table", v), int'(err_cnt), vecs[v].err_after);
      if (v == 0) begin
        check_int("vec0_first_byte", int'(frame_cube_flat[511:504]), 8'h00);
        check_int("vec0_last_byte", int'(frame_cube_flat[7:0]), 8'h3F);
      end
    end

    // Timeout after sync plus 10 data bytes.
    send_frame(8'h10, 8'h01, 8'h00, 10, -1, 1'b0);
    check_int("timeout_busy_before", int'(busy), 1);
    repeat (40 * CPB) @(negedge clk);
    exp_err++;
    after_frame("timeout");

    // Leading garbage, then a valid frame of 64 x 80.
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    send_frame(8'h80, 8'h00, 8'h00, 64, -1, 1'b1);
    after_frame("garbage");

    // Stop bit forced low on data byte 5.
    send_frame(8'h40, 8'h02, 8'h00, 6, 5, 1'b0);
    exp_err++;
    repeat (12 * CPB) @(negedge clk);
    after_frame("bad_stop");

    // Short low glitch on an idle line.
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    after_frame("glitch");

    // Reset in the middle of a frame (sync + 29 data bytes).
    send_frame(8'h20, 8'h03, 8'h00, 29, -1, 1'b0);
    check_int("midframe_busy", int'(busy), 1);
    resetn = 1'b0;
    #1;
    check("midreset_frame", frame_cube_flat, 512'd0);
    check_int("midreset_busy", int'(busy), 0);
    check_int("midreset_err", int'(err_cnt), 0);
    check_int("midreset_update", int'(frame_update), 0);
    exp_err = 0;
    last_frame = 512'd0;
    exp_q.delete();
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    send_frame(8'h77, 8'h05, 8'h00, 64, -1, 1'b1);
    after_frame("post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_frame_loader.md
Name: uart_frame_loader

Overview:
Receives 8x8x8 light-cube frames over the board UART `rx` pin and presents them as a 512-bit `frame_cube_flat` word for the Display block.
It contains a UART 8N1 receiver and a framing state machine: a sync byte, 64 data bytes and an XOR checksum.
A shadow buffer collects each frame. The output register is replaced atomically only when a frame arrives complete and valid, so Display never shows a partial frame.

Parameters:
CLK_FREQ, 100_000_000, system clock frequency in Hz.
BAUD, 115200, UART bit rate. CLKS_PER_BIT = CLK_FREQ/BAUD (integer division), and must be >= 4.
SYNC_BYTE, 8'hA5, frame start marker.
TIMEOUT_BITS, 32, maximum idle gap between bytes of one frame, in bit periods.

Ports:
clk  input  1  system clock; all logic is on the rising edge.
resetn  input  1  asynchronous active-low reset.
rx  input  1  UART serial input, idle high, asynchronous to clk.
frame_cube_flat  output  512  current frame. Byte k of the frame (k=0..63) occupies bits [8*(63-k)+7 : 8*(63-k)].
frame_update  output  1  one-cycle pulse when frame_cube_flat takes a new frame.
busy  output  1  high while a frame is in progress (state != WAIT_SYNC).
err_cnt  output  8  saturating count of aborted frames.

Behaviour:
Reset (asynchronous, resetn=0):
- frame_cube_flat=0, frame_update=0, busy=0, err_cnt=0.
- Shadow buffer cleared; state WAIT_SYNC; UART receiver in IDLE.
- Synchronizer flops set to 1.

UART receiver:
- rx passes through a 2-flop synchronizer.
- IDLE: a low on the synchronized rx starts a bit counter.
- START: at CLKS_PER_BIT/2 the line is resampled. Low → DATA. High → glitch, return to IDLE.
- DATA: 8 samples, each CLKS_PER_BIT apart, LSB first.
- STOP: sampled one bit period after the last data bit.
  - High → internal byte_valid pulses for 1 cycle with the byte.
  - Low → framing error; no byte_valid, frame_err pulses for 1 cycle.
- Receiver returns to IDLE immediately after the stop sample.

Framer FSM (driven by byte_valid and frame_err):
- WAIT_SYNC: a byte equal to SYNC_BYTE → DATA with idx=0 and csum=0. Any other byte is ignored, with no error. frame_err here is ignored.
- DATA: each byte is written to shadow slot idx, csum ^= byte, idx++. After the byte with idx=63 is stored → CHECK.
- CHECK: the next byte is compared with csum.
  - Equal: at T+1 (T = cycle byte_valid is asserted), frame_cube_flat is loaded from the shadow buffer and frame_update=1 for that cycle only. State → WAIT_SYNC.
  - Not equal: abort.
- A byte equal to SYNC_BYTE arriving in DATA is treated as data, not as a resync.

Abort (from DATA or CHECK):
- Triggered by checksum mismatch, frame_err, or timeout.
- Timeout: an idle counter reaches TIMEOUT_BITS*CLKS_PER_BIT cycles since the last byte_valid with no start bit detected.
- On abort: err_cnt++ (saturating at 255), state → WAIT_SYNC, frame_cube_flat unchanged, no frame_update.

Other rules:
- The idle counter runs only in DATA and CHECK. It resets on every byte_valid and while the receiver is outside IDLE.
- busy=1 in DATA and CHECK.
- A reset mid-frame discards the shadow buffer, and the output returns to 0.
- The shadow buffer is not cleared between frames; every slot is always overwritten before it is used.
- Back-to-back frames with zero gap are supported. The next sync byte may begin on the start bit immediately after the checksum byte's stop bit.

Test Plan:
(Simulate with CLK_FREQ=1600, BAUD=100, so 16 clks/bit.)
1. Send A5, bytes 00..3F, checksum 00 (XOR of 0..63 = 0) → one frame_update pulse; frame_cube_flat[511:504]=00, [7:0]=3F; err_cnt=0.
2. Send A5, 64×FF, then 00 → frame_update pulses; frame_cube_flat = all ones (512'h…ff). Then send A5, 64×FF, 01 → no pulse, output still all ones, err_cnt=1.
3. Leading garbage 12 34 A5 followed by a valid frame of 64×80 with checksum 00 → frame accepted, no error; the garbage is ignored.
4. Send A5 and 10 data bytes, then hold rx high for more than 32 bit times → busy falls, err_cnt=1, output unchanged. A following valid frame is accepted.
5. A stop bit forced low on data byte 5 → abort, err_cnt=1. A 4-clk low glitch on idle rx → no byte, state unchanged.
6. Assert resetn low mid-frame (after 30 bytes) → all outputs are 0 immediately. After release, a complete valid frame is accepted normally.
